// File: rtl/aes_bist_pkg.sv
// Shared types and constants for the AES BIST run controller.
// Holds the controller state encoding and the default golden MISR signature.
package aes_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT    = 3'd2,
        COMPACT = 3'd3,
        SETTLE  = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } bist_state_e;

    localparam logic [7:0] GOLDEN_SIG_DEFAULT = 8'hC0;

endpackage

// File: rtl/aes_bist_ctrl.sv
// Sequences one AES BIST run: load, wait for the core, compact, then compare the MISR signature.
// All outputs are registered from the next-state decode, so none depends combinationally on an input.
module aes_bist_ctrl
    import aes_bist_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES    = 32,
    parameter int unsigned COMPACT_CYCLES = 16,
    parameter int unsigned NUM_BLOCKS     = 4,
    parameter int unsigned TIMEOUT        = 255,
    parameter logic [7:0]  GOLDEN_SIG     = GOLDEN_SIG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       aes_done,
    input  logic [7:0] signature,
    output logic       bist_en,
    output logic       aes_start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic       timeout
);

    localparam int unsigned PH_MAX = (LOAD_CYCLES > COMPACT_CYCLES) ? LOAD_CYCLES : COMPACT_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned BLK_W  = $clog2(NUM_BLOCKS + 1);

    localparam logic [PH_W-1:0]  LOAD_LAST    = PH_W'(LOAD_CYCLES - 1);
    localparam logic [PH_W-1:0]  COMPACT_LAST = PH_W'(COMPACT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT);
    localparam logic [BLK_W-1:0] BLK_LAST     = BLK_W'(NUM_BLOCKS - 1);

    bist_state_e      state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             bist_en_q, bist_en_d;
    logic             aes_start_q, aes_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic             sig_match;

    assign sig_match = (signature == GOLDEN_SIG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            wdog_q      <= '0;
            blk_q       <= '0;
            bist_en_q   <= 1'b0;
            aes_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            wdog_q      <= wdog_d;
            blk_q       <= blk_d;
            bist_en_q   <= bist_en_d;
            aes_start_q <= aes_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wdog_d    = wdog_q;
        blk_d     = blk_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    blk_d   = '0;
                end
            end
            LOAD: begin
                if (phase_q == LOAD_LAST) state_d = WAIT;
                else                      phase_d = phase_q + 1'b1;
            end
            WAIT: begin
                // aes_done takes priority over an expiring watchdog in the same cycle
                if (aes_done) begin
                    state_d = COMPACT;
                end else if (wdog_q == WD_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            COMPACT: begin
                if (phase_q == COMPACT_LAST) begin
                    if (blk_q < BLK_LAST) begin
                        state_d = LOAD;
                        blk_d   = blk_q + 1'b1;
                    end else begin
                        state_d = SETTLE;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SETTLE: state_d = CHECK;
            CHECK: begin
                state_d = DONE;
                pass_d  = sig_match;
                fail_d  = !sig_match;
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            phase_d = '0;
            wdog_d  = '0;
        end

        bist_en_d   = (state_d == LOAD) || (state_d == COMPACT);
        aes_start_d = (state_d == LOAD) && (state_q != LOAD);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
    end

    assign bist_en   = bist_en_q;
    assign aes_start = aes_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Randomized bench for aes_bist_ctrl against a segment-level timeline model of a BIST run.
// Each run is expanded into a per-cycle list of expected outputs and the inputs to drive.
module tb_aes_bist_ctrl;

    localparam int         LOAD_N = 32;
    localparam int         COMP_N = 16;
    localparam int         BLOCKS = 4;
    localparam int         TMO    = 255;
    localparam logic [7:0] GOLD   = 8'hC0;

    logic       clk;
    logic       rst;
    logic       start;
    logic       aes_done;
    logic [7:0] signature;
    logic       bist_en, aes_start, busy, done, pass, fail, timeout;
    logic [6:0] outs;

    assign outs = {bist_en, aes_start, busy, done, pass, fail, timeout};

    aes_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .aes_done  (aes_done),
        .signature (signature),
        .bist_en   (bist_en),
        .aes_start (aes_start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout)
    );

    typedef struct packed {
        logic [6:0] exp;
        logic       drv_start;
        logic       drv_done;
        logic       noise_start;
        logic       noise_done;
    } entry_t;

    entry_t     trace[$];
    int         blk_delay[BLOCKS];
    logic [7:0] run_sig;
    int         cut_idx;
    int         vectors;
    int         miscompares;
    int         obs_bist, obs_start, first_start_t, first_done_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL sim_timeout: bench did not reach its end");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic entry_t mk(input logic [6:0] exp, input logic ds, input logic dd,
                                  input logic ns, input logic nd);
        entry_t e;
        e.exp         = exp;
        e.drv_start   = ds;
        e.drv_done    = dd;
        e.noise_start = ns;
        e.noise_done  = nd;
        return e;
    endfunction

    // Expand blk_delay/run_sig into a cycle list: delay d means aes_done arrives in WAIT cycle d (0-based), -1 means never.
    task automatic buildTrace();
        int         n_idle;
        logic       to_hit;
        logic       exp_pass;
        trace.delete();
        cut_idx = -1;
        to_hit  = 1'b0;
        n_idle  = $urandom_range(0, 3);
        for (int i = 0; i < n_idle; i++) trace.push_back(mk(7'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        trace.push_back(mk(7'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        for (int b = 0; b < BLOCKS; b++) begin
            for (int i = 0; i < LOAD_N; i++)
                trace.push_back(mk((i == 0) ? 7'b1110000 : 7'b1010000, 1'b0, 1'b0, 1'b1, 1'b1));
            if (blk_delay[b] < 0) begin
                for (int i = 0; i <= TMO; i++) trace.push_back(mk(7'b0010000, 1'b0, 1'b0, 1'b1, 1'b0));
                to_hit = 1'b1;
                break;
            end
            for (int i = 0; i <= blk_delay[b]; i++)
                trace.push_back(mk(7'b0010000, 1'b0, (i == blk_delay[b]), 1'b1, 1'b0));
            for (int i = 0; i < COMP_N; i++) begin
                if (b == 2 && i == COMP_N / 2) cut_idx = trace.size();
                trace.push_back(mk(7'b1010000, 1'b0, 1'b0, 1'b1, 1'b1));
            end
        end
        if (!to_hit) begin
            trace.push_back(mk(7'b0010000, 1'b0, 1'b0, 1'b1, 1'b1));
            trace.push_back(mk(7'b0010000, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        exp_pass = !to_hit && (run_sig == GOLD);
        for (int i = 0; i < 4; i++)
            trace.push_back(mk({3'b000, 1'b1, exp_pass, !exp_pass, to_hit}, 1'b0, 1'b0, 1'b1, 1'b1));
    endtask

    task automatic applyStimulus(input entry_t e);
        start     = e.drv_start | (e.noise_start & ($urandom_range(0, 7) == 0));
        aes_done  = e.drv_done  | (e.noise_done  & ($urandom_range(0, 7) == 0));
        signature = run_sig;
    endtask

    task automatic runTrace(input string name, input int last);
        obs_bist      = 0;
        obs_start     = 0;
        first_start_t = -1;
        first_done_t  = -1;
        for (int t = 0; t < last; t++) begin
            applyStimulus(trace[t]);
            checkOutput($sformatf("%s c%0d", name, t), 32'(outs), 32'(trace[t].exp));
            if (bist_en) obs_bist++;
            if (aes_start) begin
                obs_start++;
                if (first_start_t < 0) first_start_t = t;
            end
            if (done && first_done_t < 0) first_done_t = t;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        aes_done = 1'b0;
    endtask

    task automatic resetDut();
        rst      = 1'b0;
        start    = 1'b0;
        aes_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("in_reset", 32'(outs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic setDelays(input int d);
        for (int b = 0; b < BLOCKS; b++) blk_delay[b] = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        aes_done    = 1'b0;
        signature   = 8'h00;
        run_sig     = GOLD;

        resetDut();
        setDelays(10);
        run_sig = GOLD;
        buildTrace();
        runTrace("nominal", trace.size());
        checkOutput("nominal_bist_cycles", 32'(obs_bist), 32'(BLOCKS * (LOAD_N + COMP_N)));
        checkOutput("nominal_aes_starts", 32'(obs_start), 32'(BLOCKS));
        checkOutput("nominal_pass", 32'(pass), 32'd1);

        resetDut();
        run_sig = 8'hC1;
        buildTrace();
        runTrace("mismatch", trace.size());
        checkOutput("mismatch_flags", 32'({pass, fail, timeout}), 32'b010);

        resetDut();
        setDelays(10);
        blk_delay[0] = -1;
        run_sig      = GOLD;
        buildTrace();
        runTrace("timeout", trace.size());
        checkOutput("timeout_latency", 32'(first_done_t - first_start_t), 32'(LOAD_N + TMO + 1));
        checkOutput("timeout_flags", 32'({pass, fail, timeout}), 32'b011);

        resetDut();
        setDelays(10);
        blk_delay[0] = TMO;
        buildTrace();
        runTrace("boundary", trace.size());
        checkOutput("boundary_no_timeout", 32'(timeout), 32'd0);

        for (int r = 0; r < 8; r++) begin
            resetDut();
            for (int b = 0; b < BLOCKS; b++)
                blk_delay[b] = ($urandom_range(0, 5) == 0) ? TMO : int'($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) blk_delay[$urandom_range(0, BLOCKS - 1)] = -1;
            run_sig = ($urandom_range(0, 1) == 0) ? GOLD : 8'($urandom);
            buildTrace();
            runTrace($sformatf("rand%0d", r), trace.size());
        end

        resetDut();
        setDelays(10);
        run_sig = GOLD;
        buildTrace();
        runTrace("pre_rst", cut_idx);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst", 32'(outs), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start    = $urandom_range(0, 1);
            aes_done = $urandom_range(0, 1);
            @(negedge clk);
            checkOutput($sformatf("held_rst c%0d", i), 32'(outs), 32'd0);
        end
        start    = 1'b0;
        aes_done = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        buildTrace();
        runTrace("rerun", trace.size());
        checkOutput("rerun_pass", 32'(pass), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
